pos_scan_seq: RTL and testbench

POS_SCAN_SEQ -- requirements
Module: pos_scan_seq

---
 rtl/pos_scan_seq.sv | 206 ++++++++++++++++++++
 tb/tb_pos_scan_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_scan_seq.sv
// Position scan sequencer: steps a PID setpoint from pos_start to pos_end, waiting for settle then dwelling at each point.
// Optional settle timeout is enabled by defining POS_SEQ_TIMEOUT_EN.
module pos_scan_seq #(
   parameter int SETTLE_W = 8
) (
   input  logic                clk_pid,
   input  logic                sys_rstn,
   input  logic                start,
   input  logic                stop,
   input  logic [15:0]         pos_start,
   input  logic [15:0]         pos_end,
   input  logic [15:0]         step,
   input  logic [15:0]         dwell,
   input  logic [15:0]         settle_tol,
   input  logic [SETTLE_W-1:0] settle_cnt,
   input  logic [15:0]         settle_timeout,
   input  logic [15:0]         pos_adc,
   output logic [15:0]         pos_target,
   output logic                busy,
   output logic                point_strobe,
   output logic [15:0]         point_idx,
   output logic                done,
   output logic                aborted,
   output logic                fault
);

   typedef enum logic [1:0] {IDLE, SETTLE, DWELL, STEP} state_t;

   state_t                state_q, state_d;
   logic [15:0]           pos_target_q, pos_target_d;
   logic [15:0]           point_idx_q, point_idx_d;
   logic [SETTLE_W-1:0]   run_cnt_q, run_cnt_d;
   logic [15:0]           dwell_cnt_q, dwell_cnt_d;
   logic                  point_strobe_q, point_strobe_d;
   logic                  done_q, done_d;
   logic                  aborted_q, aborted_d;

   logic signed [16:0]    pos_err;
   logic [16:0]           pos_err_abs;
   logic                  in_tol;
   logic [SETTLE_W:0]     run_inc;
   logic                  settled;
   logic                  dir_up;
   logic [15:0]           next_target;

`ifdef POS_SEQ_TIMEOUT_EN
   logic [15:0]           settle_tmr_q, settle_tmr_d;
   logic                  fault_q, fault_d;
   logic [16:0]           tmr_inc;
   logic                  timed_out;
`else
   logic                  unused_timeout;
   assign unused_timeout = ^settle_timeout;
`endif

   // Error evaluated signed in 17 bits so the full unsigned range cannot wrap.
   assign pos_err     = $signed({1'b0, pos_target_q}) - $signed({1'b0, pos_adc});
   assign pos_err_abs = (pos_err < 0) ? 17'(-pos_err) : 17'(pos_err);
   assign in_tol      = (pos_err_abs <= {1'b0, settle_tol});
   assign run_inc     = {1'b0, run_cnt_q} + 1'b1;
   assign settled     = (settle_cnt == '0) || (in_tol && (run_inc >= {1'b0, settle_cnt}));

`ifdef POS_SEQ_TIMEOUT_EN
   assign tmr_inc   = {1'b0, settle_tmr_q} + 17'd1;
   assign timed_out = (settle_timeout != 16'd0) && (tmr_inc >= {1'b0, settle_timeout});
`endif

   // Next point moves toward the live pos_end, clamping rather than overshooting or wrapping.
   assign dir_up = (pos_end >= pos_start);
   always_comb begin
      next_target = pos_end;
      if (step != 16'd0) begin
         if (dir_up) begin
            if ((pos_target_q < pos_end) && ((pos_end - pos_target_q) > step))
               next_target = pos_target_q + step;
         end else begin
            if ((pos_target_q > pos_end) && ((pos_target_q - pos_end) > step))
               next_target = pos_target_q - step;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      pos_target_d   = pos_target_q;
      point_idx_d    = point_idx_q;
      run_cnt_d      = run_cnt_q;
      dwell_cnt_d    = dwell_cnt_q;
      point_strobe_d = 1'b0;
      done_d         = 1'b0;
      aborted_d      = 1'b0;
`ifdef POS_SEQ_TIMEOUT_EN
      settle_tmr_d   = settle_tmr_q;
      fault_d        = fault_q;
`endif

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d      = SETTLE;
               pos_target_d = pos_start;
               point_idx_d  = 16'd0;
               run_cnt_d    = '0;
`ifdef POS_SEQ_TIMEOUT_EN
               settle_tmr_d = 16'd0;
               fault_d      = 1'b0;
`endif
            end
         end
         SETTLE: begin
`ifdef POS_SEQ_TIMEOUT_EN
            settle_tmr_d = tmr_inc[15:0];
`endif
            if (settled) begin
               state_d        = DWELL;
               point_strobe_d = 1'b1;
               dwell_cnt_d    = 16'd0;
               run_cnt_d      = '0;
            end else begin
               run_cnt_d = in_tol ? run_inc[SETTLE_W-1:0] : '0;
`ifdef POS_SEQ_TIMEOUT_EN
               if (timed_out) begin
                  state_d = IDLE;
                  fault_d = 1'b1;
               end
`endif
            end
         end
         DWELL: begin
            if (dwell_cnt_q >= dwell) begin
               if (pos_target_q == pos_end) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = STEP;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q + 16'd1;
            end
         end
         STEP: begin
            state_d      = SETTLE;
            pos_target_d = next_target;
            point_idx_d  = (point_idx_q == 16'hFFFF) ? point_idx_q : point_idx_q + 16'd1;
            run_cnt_d    = '0;
`ifdef POS_SEQ_TIMEOUT_EN
            settle_tmr_d = 16'd0;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides every other transition and freezes the setpoint where it is.
      if (stop && (state_q != IDLE)) begin
         state_d        = IDLE;
         pos_target_d   = pos_target_q;
         point_idx_d    = point_idx_q;
         point_strobe_d = 1'b0;
         done_d         = 1'b0;
         aborted_d      = 1'b1;
      end
   end

   always_ff @(posedge clk_pid or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q        <= IDLE;
         pos_target_q   <= 16'd32768;
         point_idx_q    <= 16'd0;
         run_cnt_q      <= '0;
         dwell_cnt_q    <= 16'd0;
         point_strobe_q <= 1'b0;
         done_q         <= 1'b0;
         aborted_q      <= 1'b0;
`ifdef POS_SEQ_TIMEOUT_EN
         settle_tmr_q   <= 16'd0;
         fault_q        <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         pos_target_q   <= pos_target_d;
         point_idx_q    <= point_idx_d;
         run_cnt_q      <= run_cnt_d;
         dwell_cnt_q    <= dwell_cnt_d;
         point_strobe_q <= point_strobe_d;
         done_q         <= done_d;
         aborted_q      <= aborted_d;
`ifdef POS_SEQ_TIMEOUT_EN
         settle_tmr_q   <= settle_tmr_d;
         fault_q        <= fault_d;
`endif
      end
   end

   assign pos_target   = pos_target_q;
   assign busy         = (state_q != IDLE);
   assign point_strobe = point_strobe_q;
   assign point_idx    = point_idx_q;
   assign done         = done_q;
   assign aborted      = aborted_q;
`ifdef POS_SEQ_TIMEOUT_EN
   assign fault        = fault_q;
`else
   assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_pos_scan_seq.sv
// Directed bench for pos_scan_seq: scans, clamping, settle timing, abort, reset and (optionally) timeout.
module tb_pos_scan_seq;

   logic        clk_pid = 1'b0;
   logic        sys_rstn;
   logic        start, stop;
   logic [15:0] pos_start, pos_end, step, dwell, settle_tol, settle_timeout;
   logic [7:0]  settle_cnt;
   logic [15:0] pos_adc, pos_target, point_idx, adc_man;
   logic        busy, point_strobe, done, aborted, fault, track;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] tgt_q[$];
   logic [15:0] idx_q[$];
   int          done_n, abrt_n;
   logic [15:0] exp_t [4];
   int          n_edges;

   always #5 clk_pid = ~clk_pid;

   // ADC either follows the setpoint exactly or holds a bench-chosen value.
   assign pos_adc = track ? pos_target : adc_man;

   pos_scan_seq #(.SETTLE_W(8)) dut (
      .clk_pid(clk_pid), .sys_rstn(sys_rstn), .start(start), .stop(stop),
      .pos_start(pos_start), .pos_end(pos_end), .step(step), .dwell(dwell),
      .settle_tol(settle_tol), .settle_cnt(settle_cnt), .settle_timeout(settle_timeout),
      .pos_adc(pos_adc), .pos_target(pos_target), .busy(busy), .point_strobe(point_strobe),
      .point_idx(point_idx), .done(done), .aborted(aborted), .fault(fault)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_pid);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      if (point_strobe) begin
         tgt_q.push_back(pos_target);
         idx_q.push_back(point_idx);
      end
      if (done)    done_n++;
      if (aborted) abrt_n++;
   endtask

   task automatic clear_log();
      tgt_q.delete();
      idx_q.delete();
      done_n = 0;
      abrt_n = 0;
   endtask

   task automatic cfg(input logic [15:0] ps, input logic [15:0] pe, input logic [15:0] st,
                      input logic [15:0] dw, input logic [7:0] sc, input logic [15:0] tol);
      pos_start = ps; pos_end = pe; step = st; dwell = dw; settle_cnt = sc; settle_tol = tol;
   endtask

   task automatic go();
      clear_log();
      start = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   // Counts edges until a strobe appears (bounded); result left in n_edges.
   task automatic wait_strobe(input string tag, input int exp_edges);
      n_edges = 0;
      while (!point_strobe && n_edges < 100) begin
         tick();
         n_edges++;
      end
      chk(tag, n_edges, exp_edges);
   endtask

   task automatic chk_scan(input string tag, input int n);
      chk({tag, "_npts"}, tgt_q.size(), n);
      for (int i = 0; i < n && i < tgt_q.size(); i++) begin
         chk($sformatf("%s_tgt%0d", tag, i), {16'd0, tgt_q[i]}, {16'd0, exp_t[i]});
         chk($sformatf("%s_idx%0d", tag, i), {16'd0, idx_q[i]}, i);
      end
      chk({tag, "_done"}, done_n, 1);
      chk({tag, "_abrt"}, abrt_n, 0);
      $display("scan %s: %0d points, done=%0d", tag, tgt_q.size(), done_n);
   endtask

   initial begin
      sys_rstn = 1'b0; start = 1'b0; stop = 1'b0; track = 1'b1; adc_man = 16'd0;
      settle_timeout = 16'd0;
      cfg(16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 16'd0);
      clear_log();
      tick(); tick();
      chk("rst_target", {16'd0, pos_target}, 32'd32768);
      chk("rst_idx", {16'd0, point_idx}, 32'd0);
      chk("rst_flags", {27'd0, busy, point_strobe, done, aborted, fault}, 32'd0);
      #2 sys_rstn = 1'b1;
      tick();

      // Upward scan with exact tracking
      cfg(16'd1000, 16'd1300, 16'd100, 16'd3, 8'd2, 16'd10);
      go();
      chk("start_target", {16'd0, pos_target}, 32'd1000);
      chk("start_busy", {31'd0, busy}, 32'd1);
      wait_idle("up_idle");
      exp_t = '{16'd1000, 16'd1100, 16'd1200, 16'd1300};
      chk_scan("up", 4);

      // Downward scan with last step clamped
      cfg(16'd5000, 16'd4750, 16'd100, 16'd1, 8'd1, 16'd10);
      go(); wait_idle("down_idle");
      exp_t = '{16'd5000, 16'd4900, 16'd4800, 16'd4750};
      chk_scan("down", 4);

      // step=0 jumps straight to the end point
      cfg(16'd100, 16'd900, 16'd0, 16'd0, 8'd1, 16'd10);
      go(); wait_idle("step0_idle");
      exp_t = '{16'd100, 16'd900, 16'd0, 16'd0};
      chk_scan("step0", 2);

      // Single point when start equals end
      cfg(16'd777, 16'd777, 16'd50, 16'd2, 8'd2, 16'd10);
      go(); wait_idle("single_idle");
      exp_t = '{16'd777, 16'd0, 16'd0, 16'd0};
      chk_scan("single", 1);

      // Clamp near the top and bottom of the 16-bit range
      cfg(16'd65000, 16'd65535, 16'd1000, 16'd0, 8'd1, 16'd10);
      go(); wait_idle("top_idle");
      exp_t = '{16'd65000, 16'd65535, 16'd0, 16'd0};
      chk_scan("top", 2);
      cfg(16'd500, 16'd0, 16'd1000, 16'd0, 8'd1, 16'd10);
      go(); wait_idle("bot_idle");
      exp_t = '{16'd500, 16'd0, 16'd0, 16'd0};
      chk_scan("bot", 2);

      // Settle: 50 off holds off the strobe; in tolerance then strobes settle_cnt edges later
      track = 1'b0; adc_man = 16'd2050;
      cfg(16'd2000, 16'd2000, 16'd1, 16'd0, 8'd3, 16'd10);
      go();
      repeat (5) tick();
      chk("settle_off_nostrobe", tgt_q.size(), 0);
      adc_man = 16'd2000;
      wait_strobe("settle_latency", 3);
      wait_idle("settle_idle");

      // Tolerance boundary: 11 below is out, exactly 10 above is in
      adc_man = 16'd1989;
      cfg(16'd2000, 16'd2000, 16'd1, 16'd0, 8'd2, 16'd10);
      go();
      repeat (4) tick();
      chk("tol_below_nostrobe", tgt_q.size(), 0);
      adc_man = 16'd2010;
      wait_strobe("tol_edge_latency", 2);
      wait_idle("tol_idle");

      // settle_cnt=0 leaves SETTLE after one cycle even far off target
      adc_man = 16'd9999;
      cfg(16'd3000, 16'd3000, 16'd1, 16'd0, 8'd0, 16'd10);
      go();
      wait_strobe("cnt0_latency", 1);
      wait_idle("cnt0_idle");

      // Stop during DWELL of point 2
      track = 1'b1;
      cfg(16'd1000, 16'd1300, 16'd100, 16'd3, 8'd2, 16'd10);
      go();
      n_edges = 0;
      while (!(point_strobe && point_idx == 16'd2) && n_edges < 200) begin
         tick();
         n_edges++;
      end
      chk("stop_reach_pt2", {16'd0, point_idx}, 32'd2);
      stop = 1'b1;
      tick();
      chk("stop_aborted", {31'd0, aborted}, 32'd1);
      chk("stop_busy", {31'd0, busy}, 32'd0);
      chk("stop_target", {16'd0, pos_target}, 32'd1200);
      tick();
      chk("stop_pulse_1cyc", {31'd0, aborted}, 32'd0);
      repeat (10) tick();
      chk("stop_no_done", done_n, 0);
      chk("stop_abrt_cnt", abrt_n, 1);
      start = 1'b1; stop = 1'b1;
      tick();
      chk("startstop_busy", {31'd0, busy}, 32'd0);
      chk("startstop_target", {16'd0, pos_target}, 32'd1200);
      chk("startstop_noabrt", {31'd0, aborted}, 32'd0);

      // Settle that never succeeds
      track = 1'b0; adc_man = 16'd0; settle_timeout = 16'd20;
      cfg(16'd4000, 16'd4000, 16'd1, 16'd0, 8'd2, 16'd10);
      go();
`ifdef POS_SEQ_TIMEOUT_EN
      repeat (19) tick();
      chk("tmo_pre_busy", {31'd0, busy}, 32'd1);
      chk("tmo_pre_fault", {31'd0, fault}, 32'd0);
      tick();
      chk("tmo_fault", {31'd0, fault}, 32'd1);
      chk("tmo_idle", {31'd0, busy}, 32'd0);
      chk("tmo_target", {16'd0, pos_target}, 32'd4000);
      chk("tmo_no_done", done_n, 0);
      repeat (3) tick();
      chk("tmo_sticky", {31'd0, fault}, 32'd1);
      go();
      chk("tmo_clear", {31'd0, fault}, 32'd0);
`else
      repeat (40) tick();
      chk("notmo_busy", {31'd0, busy}, 32'd1);
      chk("notmo_fault", {31'd0, fault}, 32'd0);
`endif
      stop = 1'b1;
      tick();
      chk("tmo_stop_idle", {31'd0, busy}, 32'd0);

      // Reset asserted while in STEP
      track = 1'b1;
      cfg(16'd1000, 16'd1300, 16'd100, 16'd3, 8'd2, 16'd10);
      go();
      wait_strobe("rst_pt0_latency", 2);
      repeat (4) tick();
      clear_log();
      sys_rstn = 1'b0;
      #1;
      chk("rststep_target", {16'd0, pos_target}, 32'd32768);
      chk("rststep_idx", {16'd0, point_idx}, 32'd0);
      chk("rststep_flags", {27'd0, busy, point_strobe, done, aborted, fault}, 32'd0);
      repeat (3) tick();
      #2 sys_rstn = 1'b1;
      repeat (3) tick();
      chk("rststep_pulses", done_n + abrt_n + tgt_q.size(), 0);
      chk("rststep_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
